// File: rtl/multiword_add_sequencer_pkg.sv
// add_seq_pkg: shared width constants, FSM state encoding and operand beat type
package add_seq_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;
    typedef enum logic {IDLE = 1'b0, MID = 1'b1} seq_state_e;
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic              sub;
        logic              first;
        logic              last;
    } beat_t;
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: operand input and result output handshakes of the sequencer
interface multiword_add_sequencer_if;
    import add_seq_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic              in_sub;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_sum;
    logic              out_cout;
    logic              out_last;
    logic              out_ovf;
    modport master (
        output in_valid, in_a, in_b, in_sub, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_last, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_first, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_last, out_ovf
    );
endinterface

// File: rtl/multiword_add_sequencer_stats.sv
// add_seq_stats: wrapping counters of result words and completed operations leaving the result stage
module add_seq_stats
    import add_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_word,
    input  logic             i_last,
    output logic [CNT_W-1:0] o_words,
    output logic [CNT_W-1:0] o_ops
);
    logic [CNT_W-1:0] r_words;
    logic [CNT_W-1:0] r_ops;
    // count every word handed downstream, and the final word of each operation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words <= '0;
            r_ops   <= '0;
        end else if (i_word) begin
            r_words <= r_words + 1'b1;
            if (i_last) r_ops <= r_ops + 1'b1;
        end
    end
    assign o_words = r_words;
    assign o_ops   = r_ops;
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: feeds an external adder one word per cycle with carry chaining; ADD_SEQ_STATS_EN adds stat counters
module multiword_add_sequencer
    import add_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    multiword_add_sequencer_if.slave bus,
    output logic [WORD_W-1:0]        o_add_a,
    output logic [WORD_W-1:0]        o_add_b,
    output logic                     o_add_cin,
    input  logic [WORD_W-1:0]        i_add_sum,
    input  logic                     i_add_cout,
    output logic                     o_err
`ifdef ADD_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]         o_stat_words,
    output logic [CNT_W-1:0]         o_stat_ops
`endif
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_MID  = MID;

    logic [0:0]        r_state;
    beat_t             r_s1;
    logic              r_s1_valid;
    logic              r_carry;
    logic              r_err;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_sum;
    logic              r_out_cout;
    logic              r_out_last;
    logic              r_out_ovf;
    logic              w_s2_adv;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_first;
    logic              w_proto_err;
    logic              w_ovf;

    // handshake, chain-restart and signed-overflow decisions
    always_comb begin
        w_s2_adv    = !r_out_valid || bus.out_ready;
        w_in_ready  = !r_s1_valid || w_s2_adv;
        w_accept    = bus.in_valid && w_in_ready;
        w_first     = bus.in_first || (r_state == ST_IDLE);
        w_proto_err = bus.in_first ? (r_state == ST_MID) : (r_state == ST_IDLE);
        w_ovf       = r_s1.last && (r_s1.a[WORD_W-1] == r_s1.b[WORD_W-1]) &&
                      (i_add_sum[WORD_W-1] != r_s1.a[WORD_W-1]);
    end

    // operand stage: load a beat whenever the stage is free or draining this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid)
                r_s1 <= '{a: bus.in_a, b: bus.in_sub ? ~bus.in_b : bus.in_b,
                          sub: bus.in_sub, first: w_first, last: bus.in_last};
        end
    end

    // operation tracking and sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_state <= bus.in_last ? ST_IDLE : ST_MID;
            r_err   <= r_err | w_proto_err;
        end
    end

    // result stage and carry chain advance together so a stall freezes both
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_carry     <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sum  <= i_add_sum;
                r_out_cout <= i_add_cout;
                r_out_last <= r_s1.last;
                r_out_ovf  <= w_ovf;
                r_carry    <= i_add_cout;
            end
        end
    end

    assign o_add_a       = r_s1.a;
    assign o_add_b       = r_s1.b;
    assign o_add_cin     = r_s1.first ? r_s1.sub : r_carry;
    assign o_err         = r_err;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_cout  = r_out_cout;
    assign bus.out_last  = r_out_last;
    assign bus.out_ovf   = r_out_ovf;

`ifdef ADD_SEQ_STATS_EN
    add_seq_stats u_stats (
        .clk     (clk),
        .rst     (rst),
        .i_word  (r_out_valid && bus.out_ready),
        .i_last  (r_out_last),
        .o_words (o_stat_words),
        .o_ops   (o_stat_ops)
    );
`endif
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: randomized and directed checks against a wide-arithmetic operation model
module tb_multiword_add_sequencer;
    import add_seq_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        last;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiword_add_sequencer_if bus();
    logic [WORD_W-1:0] add_a, add_b, add_sum;
    logic              add_cin, add_cout, err;
`ifdef ADD_SEQ_STATS_EN
    logic [CNT_W-1:0]  stat_words, stat_ops;
    int                n_words = 0, n_ops = 0;
`endif

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_cin};

    multiword_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_add_a   (add_a),
        .o_add_b   (add_b),
        .o_add_cin (add_cin),
        .i_add_sum (add_sum),
        .i_add_cout(add_cout),
        .o_err     (err)
`ifdef ADD_SEQ_STATS_EN
        ,
        .o_stat_words(stat_words),
        .o_stat_ops  (stat_ops)
`endif
    );

    exp_t q[$];
    int   vectors = 0;
    int   misses = 0;
    int   hold = 0;
    bit   rand_ready = 1'b0;
    bit   saw_stall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            misses++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // expected words of an n-word operation from plain wide arithmetic
    task automatic push_op(input int n, input logic sub, input int n_send,
                           input logic [127:0] a, input logic [127:0] b);
        logic [159:0] m, ax, bx, res, part;
        exp_t e;
        int top;
        m   = (160'd1 << (32 * n)) - 160'd1;
        ax  = {32'd0, a} & m;
        bx  = sub ? (~{32'd0, b} & m) : ({32'd0, b} & m);
        res = ax + bx + {159'd0, sub};
        top = 32 * n - 1;
        for (int i = 0; i < n_send; i++) begin
            m      = (160'd1 << (32 * (i + 1))) - 160'd1;
            part   = (ax & m) + (bx & m) + {159'd0, sub};
            e.sum  = res[32*i +: 32];
            e.cout = part[32*(i+1)];
            e.last = (i == n - 1);
            e.ovf  = e.last && (ax[top] == bx[top]) && (res[top] != ax[top]);
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic first, input logic last);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_first = first;
        bus.in_last  = last;
        while (!bus.in_ready) begin
            saw_stall = 1'b1;
            if (++t > 200) begin
                $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, want 1", t);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input int n, input logic sub, input int n_send, input logic bad_first,
                          input logic [127:0] a, input logic [127:0] b);
        push_op(n, sub, n_send, a, b);
        for (int i = 0; i < n_send; i++)
            send(a[32*i +: 32], b[32*i +: 32], sub, (i == 0) ? !bad_first : 1'b0, i == n - 1);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            vectors++;
            misses++;
            $display("FAIL drain_timeout: got %0d words pending, want 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
`ifdef ADD_SEQ_STATS_EN
        n_words = 0;
        n_ops   = 0;
`endif
    endtask

    // downstream readiness: forced low while hold is pending, else steady or random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else
                bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // every word handed downstream must match the model in order
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
`ifdef ADD_SEQ_STATS_EN
                n_words++;
                if (bus.out_last) n_ops++;
`endif
                if (q.size() == 0) begin
                    vectors++;
                    misses++;
                    $display("FAIL unexpected_word: got sum %h, want no word", bus.out_sum);
                end else begin
                    e = q.pop_front();
                    chk("word{sum,cout,last,ovf}",
                        {29'd0, bus.out_sum, bus.out_cout, bus.out_last, bus.out_ovf}, {29'd0, e});
                end
            end
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_sub = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_flags", {bus.out_cout, bus.out_last, bus.out_ovf}, 0);
        chk("rst_err", err, 0);
        chk("rst_add_ab", {add_a, add_b}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;

        run_op(1, 1'b0, 1, 1'b0, 128'hFFFF_FFFF, 128'h1);
        @(posedge clk);
        #1;
        chk("add1_valid", bus.out_valid, 1);
        chk("add1_sum", bus.out_sum, 32'h0);
        chk("add1_cout_last_ovf", {bus.out_cout, bus.out_last, bus.out_ovf}, 3'b110);
        drain();

        run_op(2, 1'b0, 2, 1'b0, 128'hFFFF_FFFF, 128'h1);
        chk("add64_w0", {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_last}, {1'b1, 32'h0, 2'b10});
        @(posedge clk);
        #1;
        chk("add64_w1", {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_last}, {1'b1, 32'h1, 2'b01});
        drain();

        run_op(1, 1'b1, 1, 1'b0, 128'h8000_0000, 128'h1);
        @(posedge clk);
        #1;
        chk("sub_ovf_sum", bus.out_sum, 32'h7FFF_FFFF);
        chk("sub_ovf_cout_last_ovf", {bus.out_cout, bus.out_last, bus.out_ovf}, 3'b111);
        drain();

        saw_stall = 1'b0;
        push_op(3, 1'b0, 3, 128'h0000_0001_FFFF_FFFF_FFFF_FFFF, 128'h0000_0002_0000_0000_0000_0001);
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        hold = 4;
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        send(32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
        drain();
        chk("bp_in_ready_dropped", saw_stall, 1);

        run_op(3, 1'b0, 1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        run_op(1, 1'b1, 1, 1'b0, 128'h5, 128'h7);
        @(posedge clk);
        #1;
        chk("restart_sub_sum", {bus.out_sum, bus.out_cout, bus.out_last}, {32'hFFFF_FFFE, 2'b01});
        chk("proto_err_set", err, 1);
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("proto_err_sticky", err, 1);

        run_op(2, 1'b0, 1, 1'b0, 128'h1234, 128'h5678);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midop_rst_out_valid", bus.out_valid, 0);
        chk("midop_rst_err", err, 0);
        chk("midop_rst_add_a", add_a, 0);
        q.delete();
`ifdef ADD_SEQ_STATS_EN
        n_words = 0;
        n_ops   = 0;
`endif
        rst = 1'b0;
        run_op(1, 1'b0, 1, 1'b0, 128'h1234_5678, 128'h1111_1111);
        @(posedge clk);
        #1;
        chk("post_rst_sum", {bus.out_valid, bus.out_sum, bus.out_last}, {1'b1, 32'h2345_6789, 1'b1});
        drain();

        run_op(2, 1'b1, 2, 1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        drain();
        chk("idle_nonfirst_err", err, 1);
        do_reset();
        rst = 1'b0;

        rand_ready = 1'b1;
        repeat (150) begin
            n = $urandom_range(1, 4);
            run_op(n, 1'($urandom), n, 1'b0,
                   ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(7) == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain();
        rand_ready = 1'b0;
        drain();
        chk("legal_traffic_no_err", err, 0);
`ifdef ADD_SEQ_STATS_EN
        chk("stat_words", stat_words, n_words[CNT_W-1:0]);
        chk("stat_ops", stat_ops, n_ops[CNT_W-1:0]);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
